// File: rtl/conso_dyn_energy_accu_if.sv
// Bus between the quantised dynamic-consumption stage, the energy accumulator
// and the report/logging stage.
interface conso_dyn_energy_accu_if #(
  parameter int E_W   = 24,
  parameter int ACC_W = 48,
  parameter int CNT_W = 32
);
  logic             start_test;
  logic             energy_valid;
  logic [E_W-1:0]   energy_sample;
  logic             fin_test;
  logic             busy;
  logic [ACC_W-1:0] total_energy;
  logic [CNT_W-1:0] event_count;
  logic [CNT_W-1:0] window_cycles;
  logic [ACC_W-1:0] avg_energy;
  logic             overflow;
  logic             result_valid;

  modport master (
    output start_test, energy_valid, energy_sample, fin_test,
    input  busy, total_energy, event_count, window_cycles, avg_energy,
           overflow, result_valid
  );

  modport slave (
    input  start_test, energy_valid, energy_sample, fin_test,
    output busy, total_energy, event_count, window_cycles, avg_energy,
           overflow, result_valid
  );
endinterface

// File: rtl/conso_dyn_energy_accu.sv
// Windowed energy accumulator: sums per-event energy, counts events and cycles,
// then derives mean energy per event with a restoring shift-subtract divider.
module conso_dyn_energy_accu #(
  parameter int E_W   = 24,
  parameter int ACC_W = 48,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  conso_dyn_energy_accu_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACCU = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int             BCW      = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(ACC_W - 1);

  logic [1:0]       state;
  logic             fin_q, fin_rise;
  logic [ACC_W-1:0] tot, tot_nxt, avg, quo;
  logic [CNT_W-1:0] evc, evc_nxt, wcy, wcy_nxt;
  logic [ACC_W:0]   tot_sum, rem, rem_sh, rem_nxt, divisor;
  logic [CNT_W:0]   evc_sum, wcy_sum;
  logic             sat, ovf, rv, rem_ge;
  logic [BCW-1:0]   bit_cnt;

  // Saturating next values for one ACCU cycle; sat flags any quantity clipping.
  always_comb begin
    fin_rise = bus.fin_test & ~fin_q;
    tot_sum  = {1'b0, tot} + (ACC_W+1)'(bus.energy_sample);
    evc_sum  = {1'b0, evc} + (CNT_W+1)'(1);
    wcy_sum  = {1'b0, wcy} + (CNT_W+1)'(1);
    tot_nxt  = tot;
    evc_nxt  = evc;
    wcy_nxt  = wcy_sum[CNT_W] ? wcy : wcy_sum[CNT_W-1:0];
    sat      = wcy_sum[CNT_W];
    if (bus.energy_valid) begin
      tot_nxt = tot_sum[ACC_W] ? '1 : tot_sum[ACC_W-1:0];
      evc_nxt = evc_sum[CNT_W] ? '1 : evc_sum[CNT_W-1:0];
      sat     = sat | tot_sum[ACC_W] | evc_sum[CNT_W];
    end
  end

  // Remainder is kept one bit wider so the shifted partial never wraps.
  always_comb begin
    divisor = (ACC_W+1)'(evc);
    rem_sh  = (rem << 1) | (ACC_W+1)'(quo[ACC_W-1]);
    rem_ge  = (rem_sh >= divisor);
    rem_nxt = rem_ge ? (rem_sh - divisor) : rem_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      fin_q   <= 1'b0;
      tot     <= '0;
      evc     <= '0;
      wcy     <= '0;
      avg     <= '0;
      ovf     <= 1'b0;
      rv      <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      bit_cnt <= '0;
    end else begin
      fin_q <= bus.fin_test;
      rv    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start_test) begin
            tot   <= '0;
            evc   <= '0;
            wcy   <= '0;
            ovf   <= 1'b0;
            state <= S_ACCU;
          end
        end
        S_ACCU: begin
          if (fin_rise) begin
            // Closing cycle still accumulates; the dividend takes the updated sum.
            tot     <= tot_nxt;
            evc     <= evc_nxt;
            wcy     <= wcy_nxt;
            ovf     <= ovf | sat;
            rem     <= '0;
            quo     <= tot_nxt;
            bit_cnt <= '0;
            state   <= S_DIV;
          end else if (bus.start_test) begin
            tot <= '0;
            evc <= '0;
            wcy <= '0;
            ovf <= 1'b0;
          end else begin
            tot <= tot_nxt;
            evc <= evc_nxt;
            wcy <= wcy_nxt;
            ovf <= ovf | sat;
          end
        end
        S_DIV: begin
          if (evc == '0) begin
            avg   <= '0;
            rv    <= 1'b1;
            state <= S_DONE;
          end else begin
            rem     <= rem_nxt;
            quo     <= {quo[ACC_W-2:0], rem_ge};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              avg   <= {quo[ACC_W-2:0], rem_ge};
              rv    <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = (state == S_ACCU) || (state == S_DIV);
  assign bus.total_energy  = tot;
  assign bus.event_count   = evc;
  assign bus.window_cycles = wcy;
  assign bus.avg_energy    = avg;
  assign bus.overflow      = ovf;
  assign bus.result_valid  = rv;
endmodule

// File: tb/tb_conso_dyn_energy_accu.sv
// Randomised and directed windows on a wide (ACC_W=48) and a narrow (ACC_W=24)
// instance, compared against an arithmetic per-window reference model.
module tb_conso_dyn_energy_accu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conso_dyn_energy_accu_if #(.E_W(24), .ACC_W(48), .CNT_W(32)) ia ();
  conso_dyn_energy_accu_if #(.E_W(24), .ACC_W(24), .CNT_W(24)) ib ();

  conso_dyn_energy_accu #(.E_W(24), .ACC_W(48), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave));
  conso_dyn_energy_accu #(.E_W(24), .ACC_W(24), .CNT_W(24)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, index 0 = wide instance, 1 = narrow instance
  longint unsigned tmax[2] = '{64'hFFFF_FFFF_FFFF, 64'hFF_FFFF};
  longint unsigned cmax[2] = '{64'hFFFF_FFFF, 64'hFF_FFFF};
  int              accw[2] = '{48, 24};
  longint unsigned m_tot[2], m_cnt[2], m_cyc[2], m_avg[2];
  bit              m_ovf[2];

  logic [63:0] o_tot[2], o_cnt[2], o_cyc[2], o_avg[2];
  logic        o_ovf[2], o_rv[2], o_busy[2];

  bit          vv[64];
  int unsigned sv[64];

  task automatic snap();
    o_tot[0] = 64'(ia.total_energy);  o_tot[1] = 64'(ib.total_energy);
    o_cnt[0] = 64'(ia.event_count);   o_cnt[1] = 64'(ib.event_count);
    o_cyc[0] = 64'(ia.window_cycles); o_cyc[1] = 64'(ib.window_cycles);
    o_avg[0] = 64'(ia.avg_energy);    o_avg[1] = 64'(ib.avg_energy);
    o_ovf[0] = ia.overflow;      o_ovf[1] = ib.overflow;
    o_rv[0]  = ia.result_valid;  o_rv[1]  = ib.result_valid;
    o_busy[0] = ia.busy;         o_busy[1] = ib.busy;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_tot[i] = 0; m_cnt[i] = 0; m_cyc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_cycle(input bit v, input int unsigned s);
    for (int i = 0; i < 2; i++) begin
      if (m_cyc[i] + 1 > cmax[i]) m_ovf[i] = 1; else m_cyc[i]++;
      if (v) begin
        if (m_tot[i] + s > tmax[i]) begin m_ovf[i] = 1; m_tot[i] = tmax[i]; end
        else m_tot[i] += s;
        if (m_cnt[i] + 1 > cmax[i]) m_ovf[i] = 1; else m_cnt[i]++;
      end
    end
  endtask

  task automatic drive(input bit st, input bit v, input int unsigned s, input bit f);
    ia.start_test = st;  ib.start_test = st;
    ia.energy_valid = v; ib.energy_valid = v;
    ia.energy_sample = s[23:0]; ib.energy_sample = s[23:0];
    ia.fin_test = f;     ib.fin_test = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stim();
    for (int c = 0; c < 64; c++) begin vv[c] = 0; sv[c] = 0; end
  endtask

  task automatic chk_zero(input string tag);
    snap();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_tot%0d", tag, i), o_tot[i], 0);
      chk($sformatf("%s_cnt%0d", tag, i), o_cnt[i], 0);
      chk($sformatf("%s_cyc%0d", tag, i), o_cyc[i], 0);
      chk($sformatf("%s_avg%0d", tag, i), o_avg[i], 0);
      chk($sformatf("%s_ovf%0d", tag, i), 64'(o_ovf[i]), 0);
      chk($sformatf("%s_rv%0d", tag, i), 64'(o_rv[i]), 0);
      chk($sformatf("%s_busy%0d", tag, i), 64'(o_busy[i]), 0);
    end
  endtask

  // One measurement window of len ACCU cycles; fin_rise on cycle len.
  // rc: restart cycle (0 = none); sf: start_test together with fin_rise;
  // hold: fin_test already high over start; abort: reset N cycles into DIVIDE.
  task automatic window(input int len, input int rc, input bit sf, input bit hold,
                        input int abort);
    int lat[2];
    int npl[2];
    longint unsigned e_avg;
    int e_lat;
    drive(1'b1, 1'b0, 0, hold);
    tick();
    model_clear();
    snap();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("start_avg_hold%0d", i), o_avg[i], m_avg[i]);
      chk($sformatf("start_cyc%0d", i), o_cyc[i], 0);
      chk($sformatf("start_busy%0d", i), 64'(o_busy[i]), 1);
    end
    for (int c = 1; c <= len; c++) begin
      drive((c == rc) || (sf && c == len), vv[c], sv[c], (c == len) || (hold && c < 3));
      if (c == rc) model_clear();
      else model_cycle(vv[c], sv[c]);
      tick();
      if (c < len) begin
        snap();
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("live_tot%0d", i), o_tot[i], m_tot[i]);
          chk($sformatf("live_cyc%0d", i), o_cyc[i], m_cyc[i]);
          chk($sformatf("live_busy%0d", i), 64'(o_busy[i]), 1);
        end
      end
    end
    drive(1'b0, 1'b0, 0, 1'b1);
    if (abort > 0) begin
      repeat (abort) tick();
      #2 rst = 1'b1;
      #1 chk_zero("async_rst");
      tick();
      chk_zero("in_rst");
      rst = 1'b0;
      drive(1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 2; i++) m_avg[i] = 0;
      return;
    end
    lat = '{-1, -1};
    npl = '{0, 0};
    for (int k = 1; k <= 60; k++) begin
      snap();
      if (k == 1) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("div_busy%0d", i), 64'(o_busy[i]), 1);
          chk($sformatf("div_cnt%0d", i), o_cnt[i], m_cnt[i]);
        end
      end
      for (int i = 0; i < 2; i++)
        if (o_rv[i] === 1'b1) begin
          npl[i]++;
          if (lat[i] < 0) lat[i] = k;
        end
      tick();
    end
    snap();
    for (int i = 0; i < 2; i++) begin
      e_avg = (m_cnt[i] == 0) ? 0 : m_tot[i] / m_cnt[i];
      e_lat = (m_cnt[i] == 0) ? 2 : accw[i] + 1;
      m_avg[i] = e_avg;
      chk($sformatf("tot%0d", i), o_tot[i], m_tot[i]);
      chk($sformatf("cnt%0d", i), o_cnt[i], m_cnt[i]);
      chk($sformatf("cyc%0d", i), o_cyc[i], m_cyc[i]);
      chk($sformatf("ovf%0d", i), 64'(o_ovf[i]), 64'(m_ovf[i]));
      chk($sformatf("avg%0d", i), o_avg[i], e_avg);
      chk($sformatf("latency%0d", i), 64'(lat[i]), 64'(e_lat));
      chk($sformatf("pulses%0d", i), 64'(npl[i]), 1);
      chk($sformatf("done_busy%0d", i), 64'(o_busy[i]), 0);
    end
  endtask

  initial begin
    int len, rc, pct, mode;
    bit sf, hold;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 2; i++) m_avg[i] = 0;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // 1: four samples with gaps, 10-cycle window
    clr_stim();
    vv[2] = 1; sv[2] = 100; vv[4] = 1; sv[4] = 200;
    vv[6] = 1; sv[6] = 300; vv[8] = 1; sv[8] = 400;
    window(10, 0, 0, 0, 0);
    chk("t1_tot", 64'(ia.total_energy), 1000);
    chk("t1_cyc", 64'(ia.window_cycles), 10);
    chk("t1_avg", 64'(ia.avg_energy), 250);

    // fin_rise in DONE is ignored
    drive(1'b0, 1'b0, 0, 1'b0); tick();
    drive(1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("done_fin_rv", 64'(ia.result_valid), 0);
      chk("done_fin_busy", 64'(ia.busy), 0);
    end
    chk("done_fin_avg", 64'(ia.avg_energy), 250);

    // 2: empty window
    clr_stim();
    window(5, 0, 0, 0, 0);
    chk("t2_avg", 64'(ia.avg_energy), 0);

    // 3: saturation on the narrow instance
    clr_stim();
    vv[1] = 1; sv[1] = 24'hFF_FFFF; vv[2] = 1; sv[2] = 24'hFF_FFFF;
    window(3, 0, 0, 0, 0);
    chk("t3_tot", 64'(ib.total_energy), 64'hFF_FFFF);
    chk("t3_ovf", 64'(ib.overflow), 1);
    chk("t3_avg", 64'(ib.avg_energy), 64'h7F_FFFF);

    // 4: sample in the fin_rise cycle
    clr_stim();
    vv[1] = 1; sv[1] = 7; vv[2] = 1; sv[2] = 8; vv[3] = 1; sv[3] = 9;
    window(3, 0, 0, 0, 0);
    chk("t4_cnt", 64'(ia.event_count), 3);
    chk("t4_tot", 64'(ia.total_energy), 24);
    chk("t4_avg", 64'(ia.avg_energy), 8);

    // 5: mid-window restart
    clr_stim();
    vv[1] = 1; sv[1] = 10; vv[2] = 1; sv[2] = 20; vv[3] = 1; sv[3] = 30;
    vv[5] = 1; sv[5] = 50; vv[6] = 1; sv[6] = 50;
    window(7, 4, 0, 0, 0);
    chk("t5_cnt", 64'(ia.event_count), 2);
    chk("t5_tot", 64'(ia.total_energy), 100);
    chk("t5_avg", 64'(ia.avg_energy), 50);

    // fin held high across start, plus start together with fin_rise
    clr_stim();
    vv[1] = 1; sv[1] = 60; vv[4] = 1; sv[4] = 90; vv[6] = 1; sv[6] = 3;
    window(6, 0, 1, 1, 0);

    // 6: reset during DIVIDE, then a clean window
    clr_stim();
    vv[1] = 1; sv[1] = 500; vv[2] = 1; sv[2] = 700;
    window(4, 0, 0, 0, 5);
    clr_stim();
    vv[2] = 1; sv[2] = 100; vv[4] = 1; sv[4] = 200;
    vv[6] = 1; sv[6] = 300; vv[8] = 1; sv[8] = 400;
    window(10, 0, 0, 0, 0);
    chk("t6_avg", 64'(ia.avg_energy), 250);

    // randomised windows
    for (int w = 0; w < 20; w++) begin
      clr_stim();
      len  = $urandom_range(2, 40);
      pct  = $urandom_range(0, 100);
      mode = $urandom_range(0, 2);
      for (int c = 1; c <= len; c++) begin
        vv[c] = ($urandom_range(0, 99) < pct);
        case (mode)
          0:       sv[c] = $urandom_range(0, 1000);
          1:       sv[c] = $urandom_range(0, 24'hFF_FFFF);
          default: sv[c] = $urandom_range(24'hFF_FF00, 24'hFF_FFFF);
        endcase
      end
      rc   = (len > 3 && $urandom_range(0, 4) == 0) ? $urandom_range(2, len - 1) : 0;
      sf   = ($urandom_range(0, 5) == 0);
      hold = (len >= 4 && $urandom_range(0, 4) == 0);
      window(len, rc, sf, hold, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
